uart_tx_buffer: RTL and testbench
=================================

// Module: uart_tx_buffer
// PURPOSE
//  Downstream consumer of the CPU memory stage's UART write path (wrreq/uart_out/full).
//  Buffers bytes written by the core in a small FIFO and serialises them onto txd as 8N1 frames.
//  Backpressure is returned through full; the memory stage stalls the core while full is high.
// PARAMETERS
//  DEPTH_LOG2    4    FIFO depth = 2**DEPTH_LOG2 bytes
//  CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); legal range >= 2
// PORTS
//  clk     in   1  system clock; all logic on posedge
//  rst_n   in   1  synchronous reset, active-low
//  wrreq   in   1  push data_in this cycle (memory stage asserts only when full is low)
//  data_in in   8  byte to transmit (memory stage uart_out)
//  full    out  1  FIFO holds 2**DEPTH_LOG2 bytes
//  empty   out  1  FIFO holds 0 bytes
//  busy    out  1  a frame is on the line (state != IDLE)
//  txd     out  1  serial output, idle high
// BEHAVIOUR
//  Reset (rst_n low at posedge): FIFO emptied; state=IDLE; txd=1, full=0, empty=1, busy=0.
//  Reset mid-frame abandons the frame: txd=1 from the next edge, remaining FIFO bytes discarded.
//  FIFO: count 0..DEPTH, wrap-around read/write pointers; full=(count==DEPTH), empty=(count==0), both from registers.
//  Push while full is dropped, even if a pop happens in the same cycle; push+pop in one cycle leaves count unchanged.
//  FSM: IDLE -> START -> DATA(x8, LSB first) -> [PARITY] -> STOP -> IDLE or START.
//  IDLE: if !empty, pop head into shift register and enter START at the next edge.
//    Latency: push into empty FIFO at edge N; the pop happens at edge N+1; txd falls at edge N+2.
//  Each of START/DATA/PARITY/STOP holds txd for exactly CLKS_PER_BIT cycles (baud counter reloads at each bit).
//  START txd=0; DATA txd=shift[0], shift right per bit; STOP txd=1.
//  Last STOP cycle: if !empty, pop and go directly to START (no idle gap between frames); otherwise go to IDLE.
//  Frame length is 10*CLKS_PER_BIT cycles (11 with parity); busy is high for the whole frame.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP.
//  UART_TX_PARITY_EN undefined: no PARITY state; 8N1 frame.
// STRUCTURE
//  Shared package uart_pkg: state encoding (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP),
//    default CLKS_PER_BIT, frame bit-count constants.
//  Sub-module byte_fifo (DEPTH_LOG2): push/pop/count/full/empty, with a registered head read.
//  The top level holds the baud counter, the bit index, the shift register and the FSM.
// TESTING  (CLKS_PER_BIT=4, DEPTH_LOG2=2 unless noted)
//  1. Push 0xA5 after reset -> txd pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; txd falls 2 edges after push.
//  2. Push 0x00,0xFF,0x3C back-to-back -> three frames with no idle bit between them; busy high throughout;
//     empty rises during the 3rd frame.
//  3. Push 5 bytes while txd is idle -> full rises after the 4th accepted (1st already popped);
//     a 6th push while full is dropped; only 5 bytes appear on txd.
//  4. FIFO full and push coinciding with the STOP-end pop -> push dropped, count goes 4->3.
//  5. Assert rst_n=0 mid-DATA of 0x55 with 2 bytes queued -> next edge txd=1, empty=1, busy=0;
//     no further frames.
//  6. UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1 before stop; frame is 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing, data-frame constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: uart_state_t, CLKS_PER_BIT_DEFAULT, DATA_BITS, BIT_IDX_W, LAST_DATA_BIT.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // 50 MHz core clock, 115200 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = 3;
  localparam logic [BIT_IDX_W-1:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Write path from the memory stage into the UART transmit buffer.
// Latency: n/a (wires only).
// Backpressure: full tells the master to hold off; a push while full is lost.
// Signals: wrreq (push strobe), data_in (byte), full / empty (FIFO level flags).
interface uart_tx_buffer_if;
  import uart_pkg::*;

  logic                 wrreq;
  logic [DATA_BITS-1:0] data_in;
  logic                 full;
  logic                 empty;

  modport master (output wrreq, output data_in, input full, input empty);
  modport slave  (input wrreq, input data_in, output full, output empty);

endinterface

// File: rtl/uart_tx_buffer_byte_fifo.sv
// Byte FIFO of 2**DEPTH_LOG2 entries with wrap-around pointers and a registered head read.
// Latency: rd_dat holds the popped byte from the edge after pop is sampled.
// Backpressure: push is ignored while full (even with a simultaneous pop); pop ignored while empty.
// Ports: clk, rst_n (sync, active-low), push/push_dat, pop, rd_dat, full, empty.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_dat,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rd_dat,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  push_ok;
  logic                  pop_ok;

  // Gating on the registered flags keeps a full-FIFO push dropped even when a pop frees a slot.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d = count;
    if (push_ok && !pop_ok) begin
      count_d = count + CNT_ONE;
    end else if (!push_ok && pop_ok) begin
      count_d = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      rd_dat <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rd_dat <= mem[rd_ptr];
      end
      count <= count_d;
      full  <= (count_d == CNT_FULL);
      empty <= (count_d == '0);
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// UART transmit buffer: queues bytes from the memory stage and sends them as 8N1 (or 8E1) frames on txd.
// Latency: push into an empty FIFO at edge N -> pop at N+1 -> txd start bit from N+2; frames run back-to-back.
// Backpressure: full (via wr_if) is high while the FIFO holds 2**DEPTH_LOG2 bytes; pushes then are dropped.
// Ports: clk, rst_n (sync, active-low), wr_if (slave: wrreq, data_in, full, empty), busy, txd (idle high).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and stop.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_buffer_if.slave    wr_if,
  output logic               busy,
  output logic               txd
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  uart_state_t           state;
  uart_state_t           state_d;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_d;
  logic [BIT_IDX_W-1:0]  bit_idx;
  logic [BIT_IDX_W-1:0]  bit_idx_d;
  logic [DATA_BITS-1:0]  shift;
  logic [DATA_BITS-1:0]  shift_d;
  logic [DATA_BITS-1:0]  fifo_rd_dat;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  bit_end;
  logic                  line_d;
  logic                  busy_d;

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wr_if.wrreq),
    .push_dat (wr_if.data_in),
    .pop      (pop),
    .rd_dat   (fifo_rd_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign wr_if.full  = fifo_full;
  assign wr_if.empty = fifo_empty;

  assign bit_end = (cnt == '0);

  always_comb begin
    state_d   = state;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    line_d    = 1'b1;
    busy_d    = (state != ST_IDLE);
    // Baud counter parks at the reload value in IDLE and reloads at every bit boundary.
    cnt_d     = (state == ST_IDLE || bit_end) ? CNT_RELOAD : (cnt - CNT_ONE);

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        line_d = 1'b0;
        // The popped byte has settled in fifo_rd_dat by now; it stays put until the next pop.
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          shift_d   = fifo_rd_dat;
        end
      end
      ST_DATA: begin
        line_d = shift[0];
        if (bit_end) begin
          shift_d = {1'b0, shift[DATA_BITS-1:1]};
          if (bit_idx == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + BIT_IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        // Even parity over the byte still held in the FIFO head register.
        line_d = ^fifo_rd_dat;
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        line_d = 1'b1;
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= CNT_RELOAD;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
    end
  end

  // Registered line stage: txd and busy trail the state by one cycle so they line up with
  // each other and with the pop-then-start latency seen by the memory stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txd  <= 1'b1;
      busy <= 1'b0;
    end else begin
      txd  <= line_d;
      busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer with CLKS_PER_BIT=4, DEPTH_LOG2=2.
// Directed frame vectors plus hand-written sequences for back-to-back, full, drop and reset cases.
module tb_uart_tx_buffer;

  localparam int CPB = 4;
  localparam int DL2 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic txd;

  uart_tx_buffer_if wr_if();

  uart_tx_buffer #(
    .DEPTH_LOG2   (DL2),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_if (wr_if),
    .busy  (busy),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] dat;
    logic [9:0] pat;  // start, d0..d7, stop; first bit on the line is the MSB
    logic       par;  // even-parity bit for the byte
  } vec_t;

  vec_t vecs [7];

  logic [7:0] b3 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_if.wrreq   = 1'b1;
    wr_if.data_in = b;
    tick();
    wr_if.wrreq   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    wr_if.wrreq = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [10:0] expand(input logic [9:0] pat, input logic par);
`ifdef UART_TX_PARITY_EN
    return {pat[9:1], par, pat[0]};
`else
    return {par & 1'b0, pat};
`endif
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[FB-2-i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[1] = ^b;
`endif
    f[0] = 1'b1;
    return f;
  endfunction

  // Waits (bounded) for a start bit, then samples every cycle of every bit.
  // skip = cycles of the start bit already elapsed when called.
  task automatic recv(input int skip, output logic [10:0] bits, output int waited,
                      output bit to, output bit stable, output bit bok);
    bits   = '0;
    waited = 0;
    to     = 1'b0;
    stable = 1'b1;
    bok    = 1'b1;
    while (txd !== 1'b0 && waited < 200) begin
      tick();
      waited++;
    end
    if (txd !== 1'b0) begin
      to = 1'b1;
      return;
    end
    for (int b = 0; b < FB; b++) begin
      logic v;
      int   n;
      v = txd;
      n = (b == 0) ? CPB - skip : CPB;
      for (int c = 0; c < n; c++) begin
        if (txd !== v) stable = 1'b0;
        if (busy !== 1'b1) bok = 1'b0;
        tick();
      end
      bits[FB-1-b] = v;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] got;
    int          waited;
    bit          to;
    bit          stable;
    bit          bok;

    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[2] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[3] = '{8'h3C, 10'b0001111001, 1'b0};
    vecs[4] = '{8'h55, 10'b0101010101, 1'b0};
    vecs[5] = '{8'h07, 10'b0111000001, 1'b1};
    vecs[6] = '{8'h01, 10'b0100000001, 1'b1};

    wr_if.data_in = 8'h00;
    do_reset();
    chk("reset_txd",   txd,         1);
    chk("reset_busy",  busy,        0);
    chk("reset_empty", wr_if.empty, 1);
    chk("reset_full",  wr_if.full,  0);

    // Single-byte frames: latency, bit pattern, exact bit length, busy coverage.
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].dat);
      chk($sformatf("vec%0d_n_txd", i),    txd,         1);
      chk($sformatf("vec%0d_n_empty", i),  wr_if.empty, 0);
      tick();
      chk($sformatf("vec%0d_n1_txd", i),   txd,         1);
      chk($sformatf("vec%0d_n1_busy", i),  busy,        0);
      chk($sformatf("vec%0d_n1_empty", i), wr_if.empty, 1);
      tick();
      chk($sformatf("vec%0d_n2_txd", i),   txd,         0);
      recv(0, got, waited, to, stable, bok);
      chk($sformatf("vec%0d_timeout", i),  to,     0);
      chk($sformatf("vec%0d_frame", i),    got,    expand(vecs[i].pat, vecs[i].par));
      chk($sformatf("vec%0d_bitlen", i),   stable, 1);
      chk($sformatf("vec%0d_busy", i),     bok,    1);
      chk($sformatf("vec%0d_end_txd", i),  txd,    1);
      chk($sformatf("vec%0d_end_busy", i), busy,   0);
    end

    // Back-to-back frames with no idle gap.
    do_reset();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    recv(0, got, waited, to, stable, bok);
    chk("b2b_f1_frame", got, expand(10'b0000000001, 1'b0));
    chk("b2b_f1_wait",  waited, 0);
    chk("b2b_f1_busy",  bok, 1);
    chk("b2b_f2_empty", wr_if.empty, 0);
    recv(0, got, waited, to, stable, bok);
    chk("b2b_f2_frame", got, expand(10'b0111111111, 1'b0));
    chk("b2b_f2_gap",   waited, 0);
    chk("b2b_f2_busy",  bok, 1);
    chk("b2b_f3_empty", wr_if.empty, 1);
    recv(0, got, waited, to, stable, bok);
    chk("b2b_f3_frame", got, expand(10'b0001111001, 1'b0));
    chk("b2b_f3_gap",   waited, 0);
    chk("b2b_f3_busy",  bok, 1);
    chk("b2b_f3_len",   stable, 1);
    chk("b2b_end_busy", busy, 0);

    // Fill to full while idle; a push while full is dropped.
    do_reset();
    for (int k = 0; k < 4; k++) push(b3[k]);
    chk("fill_full_after4", wr_if.full, 0);
    push(b3[4]);
    chk("fill_full_after5", wr_if.full, 1);
    push(8'h99);
    chk("fill_full_after6", wr_if.full, 1);
    for (int k = 0; k < 5; k++) begin
      recv((k == 0) ? 3 : 0, got, waited, to, stable, bok);
      chk($sformatf("fill_f%0d_frame", k), got, frame_of(b3[k]));
      chk($sformatf("fill_f%0d_len", k),   stable, 1);
    end
    recv(0, got, waited, to, stable, bok);
    chk("fill_no_extra", to, 1);

    // Push while full on the same edge as the stop-end pop: dropped, count 4 -> 3.
    do_reset();
    for (int k = 0; k < 5; k++) push(b3[k]);
    chk("stoppop_full", wr_if.full, 1);
    repeat (36) tick();
    chk("stoppop_pre_full", wr_if.full, 1);
    push(8'hEE);
    chk("stoppop_full_drop", wr_if.full, 0);
    chk("stoppop_empty",     wr_if.empty, 0);
    for (int k = 1; k < 5; k++) begin
      recv(0, got, waited, to, stable, bok);
      chk($sformatf("stoppop_f%0d_frame", k), got, frame_of(b3[k]));
      chk($sformatf("stoppop_f%0d_wait", k),  waited, (k == 1) ? 1 : 0);
    end
    recv(0, got, waited, to, stable, bok);
    chk("stoppop_no_extra", to, 1);

    // Reset in the middle of a frame with bytes queued.
    do_reset();
    push(8'h55);
    push(8'h66);
    push(8'h77);
    repeat (15) tick();
    chk("midrst_pre_busy",  busy, 1);
    chk("midrst_pre_empty", wr_if.empty, 0);
    rst_n = 1'b0;
    tick();
    chk("midrst_txd",   txd,         1);
    chk("midrst_busy",  busy,        0);
    chk("midrst_empty", wr_if.empty, 1);
    chk("midrst_full",  wr_if.full,  0);
    rst_n = 1'b1;
    recv(0, got, waited, to, stable, bok);
    chk("midrst_no_frame", to, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
